inst_l1_cache_nway: RTL and testbench

//  Parametrised N-way set-associative L1 instruction cache between the core fetch stage and L2/main RAM.

---
 rtl/inst_l1_cache_nway_pkg.sv | 22 ++
 rtl/inst_l1_cache_nway_way.sv | 52 +++++
 rtl/inst_l1_cache_nway.sv | 158 +++++++++++++++
 tb/tb_inst_l1_cache_nway.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/inst_l1_cache_nway_pkg.sv
// Shared definitions for the N-way L1 instruction cache: FSM states and
// helpers that derive field widths from the cache geometry.
package inst_l1_cache_nway_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_REFILL = 2'd1,
    ST_UPDATE = 2'd2,
    ST_FLUSH  = 2'd3
  } cache_state_t;

  // Width of an index over n items; never below one bit so WAYS=1 still has a pointer.
  function automatic int unsigned field_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Byte-offset bits of a word address.
  function automatic int unsigned byte_bits(input int unsigned data_width);
    return $clog2(data_width / 8);
  endfunction

endpackage

// File: rtl/inst_l1_cache_nway_way.sv
// One way of the instruction cache: valid bits, tag array and line data.
// Combinational lookup, synchronous fill, per-set invalidate for the flush sweep.
module icache_way
  import inst_l1_cache_nway_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned SETS        = 64,
  parameter int unsigned BLOCK_WORDS = 4,
  parameter int unsigned TAG_W       = 22
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [$clog2(SETS)-1:0]        rd_index,
  input  logic [$clog2(BLOCK_WORDS)-1:0] rd_word,
  input  logic [TAG_W-1:0]               rd_tag,
  input  logic                           data_we,
  input  logic [$clog2(SETS)-1:0]        wr_index,
  input  logic [$clog2(BLOCK_WORDS)-1:0] wr_word,
  input  logic [DATA_WIDTH-1:0]          wr_data,
  input  logic                           tag_we,
  input  logic [TAG_W-1:0]               wr_tag,
  input  logic                           clr_en,
  input  logic [$clog2(SETS)-1:0]        clr_index,
  output logic                           valid_bit,
  output logic                           hit,
  output logic [DATA_WIDTH-1:0]          word
);

  logic [SETS-1:0]       valid_q;
  logic [TAG_W-1:0]      tag_q  [SETS];
  logic [DATA_WIDTH-1:0] data_q [SETS*BLOCK_WORDS];

  // Valid bits are the only state that must come out of reset cleared.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
    end else begin
      if (clr_en) valid_q[clr_index] <= 1'b0;
      if (tag_we) valid_q[wr_index]  <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (tag_we)  tag_q[wr_index]             <= wr_tag;
    if (data_we) data_q[{wr_index, wr_word}] <= wr_data;
  end

  assign valid_bit = valid_q[rd_index];
  assign hit       = valid_bit && (tag_q[rd_index] == rd_tag);
  assign word      = data_q[{rd_index, rd_word}];

endmodule

// File: rtl/inst_l1_cache_nway.sv
// N-way set-associative read-only L1 instruction cache with round-robin
// replacement, line refill from memory, full invalidate sweep and hit/miss counters.
module inst_l1_cache_nway
  import inst_l1_cache_nway_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned WAYS        = 2,
  parameter int unsigned SETS        = 64,
  parameter int unsigned BLOCK_WORDS = 4
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic                  i_re,
  output logic [DATA_WIDTH-1:0] o_inst,
  output logic                  o_busy,
  input  logic                  i_flush,
  output logic                  o_flush_busy,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  output logic                  o_mem_re,
  input  logic                  i_mem_busy,
  input  logic [DATA_WIDTH-1:0] i_mem_rdata,
  output logic [31:0]           o_hit_count,
  output logic [31:0]           o_miss_count
);

  localparam int unsigned BYTE_W = byte_bits(DATA_WIDTH);
  localparam int unsigned WORD_W = $clog2(BLOCK_WORDS);
  localparam int unsigned IDX_W  = $clog2(SETS);
  localparam int unsigned TAG_W  = ADDR_WIDTH - BYTE_W - WORD_W - IDX_W;
  localparam int unsigned RR_W   = field_width(WAYS);

  cache_state_t          state;
  logic [TAG_W-1:0]      tag_q;
  logic [IDX_W-1:0]      idx_q;
  logic [WORD_W-1:0]     word_cnt;
  logic [RR_W-1:0]       victim_q;
  logic [RR_W-1:0]       victim_c;
  logic [RR_W-1:0]       rr_q [SETS];
  logic [IDX_W-1:0]      flush_cnt;
  logic                  flush_pend;

  logic [TAG_W-1:0]      look_tag;
  logic [IDX_W-1:0]      look_idx;
  logic [WORD_W-1:0]     look_word;
  logic [WAYS-1:0]       way_hit;
  logic [WAYS-1:0]       way_valid;
  logic [DATA_WIDTH-1:0] way_word [WAYS];
  logic [DATA_WIDTH-1:0] sel_word;
  logic                  hit_any;
  logic                  lookup_hit;
  logic                  accept;

  assign look_word = WORD_W'(i_addr >> BYTE_W);
  assign look_idx  = IDX_W'(i_addr >> (BYTE_W + WORD_W));
  assign look_tag  = TAG_W'(i_addr >> (BYTE_W + WORD_W + IDX_W));
  assign accept    = (state == ST_REFILL) && !i_mem_busy;

  for (genvar g = 0; g < WAYS; g++) begin : g_way
    icache_way #(
      .DATA_WIDTH (DATA_WIDTH),
      .SETS       (SETS),
      .BLOCK_WORDS(BLOCK_WORDS),
      .TAG_W      (TAG_W)
    ) u_way (
      .clk      (i_clock),
      .rst_n    (i_reset),
      .rd_index (look_idx),
      .rd_word  (look_word),
      .rd_tag   (look_tag),
      .data_we  (accept && (victim_q == RR_W'(g))),
      .wr_index (idx_q),
      .wr_word  (word_cnt),
      .wr_data  (i_mem_rdata),
      .tag_we   ((state == ST_UPDATE) && (victim_q == RR_W'(g))),
      .wr_tag   (tag_q),
      .clr_en   (state == ST_FLUSH),
      .clr_index(flush_cnt),
      .valid_bit(way_valid[g]),
      .hit      (way_hit[g]),
      .word     (way_word[g])
    );
  end

  // Hit word mux and victim choice: first invalid way, otherwise the set's rr pointer.
  always_comb begin
    sel_word = '0;
    victim_c = rr_q[look_idx];
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (way_hit[w]) sel_word = sel_word | way_word[w];
      if (!way_valid[w]) victim_c = RR_W'(w);
    end
  end

  assign hit_any      = |way_hit;
  assign lookup_hit   = (state == ST_IDLE) && hit_any;
  assign o_busy       = i_re && !lookup_hit;
  assign o_inst       = (i_re && lookup_hit) ? sel_word : '0;
  assign o_mem_re     = (state == ST_REFILL);
  assign o_mem_addr   = ADDR_WIDTH'({tag_q, idx_q, word_cnt}) << BYTE_W;
  assign o_flush_busy = flush_pend || (state == ST_FLUSH);

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state        <= ST_IDLE;
      tag_q        <= '0;
      idx_q        <= '0;
      word_cnt     <= '0;
      victim_q     <= '0;
      flush_cnt    <= '0;
      flush_pend   <= 1'b0;
      o_hit_count  <= '0;
      o_miss_count <= '0;
      for (int s = 0; s < SETS; s++) rr_q[s] <= '0;
    end else begin
      if (i_re && lookup_hit) o_hit_count <= o_hit_count + 32'd1;
      if (i_flush && (state != ST_FLUSH)) flush_pend <= 1'b1;
      case (state)
        ST_IDLE: begin
          // A pending sweep wins over a new miss.
          if (flush_pend) begin
            state      <= ST_FLUSH;
            flush_pend <= 1'b0;
            flush_cnt  <= '0;
          end else if (i_re && !hit_any) begin
            state        <= ST_REFILL;
            tag_q        <= look_tag;
            idx_q        <= look_idx;
            word_cnt     <= '0;
            victim_q     <= victim_c;
            o_miss_count <= o_miss_count + 32'd1;
          end
        end
        ST_REFILL: begin
          if (!i_mem_busy) begin
            word_cnt <= word_cnt + WORD_W'(1);
            if (word_cnt == WORD_W'(BLOCK_WORDS - 1)) state <= ST_UPDATE;
          end
        end
        ST_UPDATE: begin
          rr_q[idx_q] <= (WAYS == 1) ? '0 : RR_W'(victim_q + RR_W'(1));
          state       <= ST_IDLE;
        end
        ST_FLUSH: begin
          flush_cnt <= flush_cnt + IDX_W'(1);
          if (flush_cnt == IDX_W'(SETS - 1)) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // The core must hold its fetch address while stalled.
  a_addr_hold: assert property (@(posedge i_clock) disable iff (!i_reset)
    (i_re && o_busy) |=> (i_addr == $past(i_addr)));

endmodule

// File: tb/tb_inst_l1_cache_nway.sv
// Self-checking bench for inst_l1_cache_nway: directed vector table, stall,
// flush and reset sequences, plus random fetch streams on alternate geometries.
module tb_inst_l1_cache_nway;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] addr;
  logic        re;
  logic [31:0] inst;
  logic        busy;
  logic        flush;
  logic        flush_busy;
  logic [31:0] mem_addr;
  logic        mem_re;
  logic        mem_busy;
  logic [31:0] mem_rdata;
  logic [31:0] hit_cnt;
  logic [31:0] miss_cnt;

  int errors = 0;
  int checks = 0;
  logic [31:0] inst_q[$];
  logic [31:0] memq[$];
  int stall_mode = 0;
  int stall_c = 0;
  int refill_cycles = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_model(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  assign mem_rdata = mem_model(mem_addr);

  inst_l1_cache_nway #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .WAYS(2), .SETS(64), .BLOCK_WORDS(4)
  ) u_dut (
    .i_clock(clk), .i_reset(rst_n), .i_addr(addr), .i_re(re), .o_inst(inst),
    .o_busy(busy), .i_flush(flush), .o_flush_busy(flush_busy),
    .o_mem_addr(mem_addr), .o_mem_re(mem_re), .i_mem_busy(mem_busy),
    .i_mem_rdata(mem_rdata), .o_hit_count(hit_cnt), .o_miss_count(miss_cnt)
  );

  // Random-stream instances: k=0 is WAYS=1/BLOCK_WORDS=2, k=1 is WAYS=4/BLOCK_WORDS=8.
  logic [31:0] r_addr [2];
  logic        r_re [2];
  logic        r_flush [2];
  logic        r_mem_busy [2];
  logic [31:0] r_inst [2];
  logic        r_busy [2];
  logic        r_flush_busy [2];
  logic [31:0] r_mem_addr [2];
  logic        r_mem_re [2];
  logic [31:0] r_hit [2];
  logic [31:0] r_miss [2];

  for (genvar g = 0; g < 2; g++) begin : g_rnd
    logic [31:0] rdata;
    assign rdata = mem_model(r_mem_addr[g]);
    inst_l1_cache_nway #(
      .ADDR_WIDTH(32), .DATA_WIDTH(32), .WAYS((g == 0) ? 1 : 4), .SETS(4),
      .BLOCK_WORDS((g == 0) ? 2 : 8)
    ) u_rnd (
      .i_clock(clk), .i_reset(rst_n), .i_addr(r_addr[g]), .i_re(r_re[g]),
      .o_inst(r_inst[g]), .o_busy(r_busy[g]), .i_flush(r_flush[g]),
      .o_flush_busy(r_flush_busy[g]), .o_mem_addr(r_mem_addr[g]),
      .o_mem_re(r_mem_re[g]), .i_mem_busy(r_mem_busy[g]), .i_mem_rdata(rdata),
      .o_hit_count(r_hit[g]), .o_miss_count(r_miss[g])
    );
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s", name);
  endtask

  // Memory side: optional 5-cycle stall per word, refill address scoreboard.
  always @(negedge clk) begin
    if (stall_mode != 0 && mem_re) begin
      mem_busy = (stall_c != 5);
      stall_c  = (stall_c == 5) ? 0 : stall_c + 1;
    end else begin
      mem_busy = 1'b0;
      stall_c  = 0;
    end
    if (rst_n && mem_re) begin
      refill_cycles++;
      if (memq.size() == 0) fail_now("mem_unexpected_read");
      else if (mem_busy) check("mem_addr_hold", mem_addr, memq[0]);
      else check("mem_addr", mem_addr, memq.pop_front());
    end
  end

  // Core side: every completed fetch is compared with the queued expectation.
  always @(negedge clk) begin
    if (rst_n && re && !busy) begin
      if (inst_q.size() == 0) fail_now("inst_unexpected");
      else check("inst", inst, inst_q.pop_front());
    end
  end

  always @(negedge clk) begin
    for (int g = 0; g < 2; g++) r_mem_busy[g] = ($urandom_range(0, 3) == 0);
  end

  task automatic start_fetch(input logic [31:0] a, input logic exp_hit);
    @(posedge clk); #1;
    addr = a;
    re   = 1'b1;
    inst_q.push_back(mem_model(a));
    if (!exp_hit)
      for (int w = 0; w < 4; w++) memq.push_back((a & ~32'hF) + 32'(w * 4));
  endtask

  task automatic wait_ready(output int lat);
    lat = 0;
    forever begin
      @(negedge clk);
      if (!busy) break;
      lat++;
      if (lat > 2000) begin
        fail_now("fetch_timeout");
        break;
      end
    end
    @(posedge clk); #1;
    re = 1'b0;
  endtask

  task automatic fetch(input logic [31:0] a, input logic exp_hit, output int lat);
    start_fetch(a, exp_hit);
    wait_ready(lat);
  endtask

  typedef struct {
    logic [31:0] addr;
    logic        hit;
    int          lat;
    int          hits;
    int          misses;
  } vec_t;

  vec_t vecs[11];

  initial begin
    int lat;
    int n;
    logic [31:0] a;

    vecs[0]  = '{32'h0000_0100, 1'b0, 6, 1, 1};
    vecs[1]  = '{32'h0000_0104, 1'b1, 0, 2, 1};
    vecs[2]  = '{32'h0000_010C, 1'b1, 0, 3, 1};
    vecs[3]  = '{32'h0000_0000, 1'b0, 6, 4, 2};
    vecs[4]  = '{32'h0000_0400, 1'b0, 6, 5, 3};
    vecs[5]  = '{32'h0000_0800, 1'b0, 6, 6, 4};
    vecs[6]  = '{32'h0000_0404, 1'b1, 0, 7, 4};
    vecs[7]  = '{32'h0000_0008, 1'b0, 6, 8, 5};
    vecs[8]  = '{32'h0000_0400, 1'b0, 6, 9, 6};
    vecs[9]  = '{32'h0000_0000, 1'b1, 0, 10, 6};
    vecs[10] = '{32'h0000_0800, 1'b0, 6, 11, 7};

    rst_n = 1'b0; addr = '0; re = 1'b0; flush = 1'b0;
    for (int k = 0; k < 2; k++) begin
      r_addr[k] = '0; r_re[k] = 1'b0; r_flush[k] = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_mem_re", 32'(mem_re), 32'd0);
    check("rst_flush_busy", 32'(flush_busy), 32'd0);
    check("rst_inst", inst, 32'd0);
    check("rst_hits", hit_cnt, 32'd0);
    check("rst_misses", miss_cnt, 32'd0);
    rst_n = 1'b1;

    // Cold miss, same-line hits, set-0 conflicts with round-robin eviction.
    for (int i = 0; i < 11; i++) begin
      fetch(vecs[i].addr, vecs[i].hit, lat);
      check($sformatf("lat[%0d]", i), 32'(lat), 32'(vecs[i].lat));
      check($sformatf("hits[%0d]", i), hit_cnt, 32'(vecs[i].hits));
      check($sformatf("misses[%0d]", i), miss_cnt, 32'(vecs[i].misses));
    end

    // Memory stalls of 5 cycles on every word.
    stall_mode = 1;
    refill_cycles = 0;
    fetch(32'h0000_0300, 1'b0, lat);
    stall_mode = 0;
    check("stall_lat", 32'(lat), 32'd26);
    check("stall_refill_cycles", 32'(refill_cycles), 32'd24);
    check("stall_misses", miss_cnt, 32'd8);

    // Flush pulse during a refill: refill finishes, then one full sweep.
    start_fetch(32'h0000_0200, 1'b0);
    repeat (2) @(negedge clk);
    @(posedge clk); #1; flush = 1'b1;
    @(posedge clk); #1; flush = 1'b0;
    @(negedge clk);
    check("flush_pending", 32'(flush_busy), 32'd1);
    check("flush_refill_busy", 32'(busy), 32'd1);
    wait_ready(lat);
    n = 0;
    forever begin
      @(negedge clk);
      if (!flush_busy) break;
      n++;
      if (n > 500) begin
        fail_now("flush_timeout");
        break;
      end
    end
    check("flush_sweep_cycles", 32'(n), 32'd64);
    check("flush_hits", hit_cnt, 32'd13);
    fetch(32'h0000_0104, 1'b0, lat);
    check("post_flush_lat_104", 32'(lat), 32'd6);
    fetch(32'h0000_0200, 1'b0, lat);
    check("post_flush_lat_200", 32'(lat), 32'd6);
    check("post_flush_misses", miss_cnt, 32'd11);

    // Asynchronous reset in the middle of a refill.
    start_fetch(32'h0000_0600, 1'b0);
    repeat (3) @(negedge clk);
    #2;
    rst_n = 1'b0;
    re    = 1'b0;
    #1;
    check("mid_rst_mem_re", 32'(mem_re), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_hits", hit_cnt, 32'd0);
    check("mid_rst_misses", miss_cnt, 32'd0);
    inst_q.delete();
    memq.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    fetch(32'h0000_0200, 1'b0, lat);
    check("after_rst_lat", 32'(lat), 32'd6);
    check("after_rst_misses", miss_cnt, 32'd1);
    check("after_rst_hits", hit_cnt, 32'd1);

    // Random fetch streams against the memory model on other geometries.
    for (int k = 0; k < 2; k++) begin
      for (int j = 0; j < 150; j++) begin
        if (j == 75) begin
          @(posedge clk); #1; r_flush[k] = 1'b1;
          @(posedge clk); #1; r_flush[k] = 1'b0;
        end
        a = 32'($urandom_range(0, 255)) << 2;
        @(posedge clk); #1;
        r_addr[k] = a;
        r_re[k]   = 1'b1;
        lat = 0;
        forever begin
          @(negedge clk);
          if (!r_busy[k]) break;
          lat++;
          if (lat > 500) begin
            fail_now($sformatf("rnd%0d_timeout", k));
            break;
          end
        end
        check($sformatf("rnd%0d[%0d]", k, j), r_inst[k], mem_model(a));
        @(posedge clk); #1;
        r_re[k] = 1'b0;
      end
      @(negedge clk);
      check($sformatf("rnd%0d_hits", k), r_hit[k], 32'd150);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
